elec_lock_actuator: RTL
=======================

Name: elec_lock_actuator

Overview:
Consumer of the 2-bit lock-check result (0 = no confirm, 1 = password correct, 2 = password wrong) and of the confirm-key pulse that triggers it. Turns each confirmed attempt into timed physical actions: a relay unlock window, a blinking error LED with a buzzer, and a lockout after repeated failures. Sits between the password checker and the board I/O (relay, LEDs, buzzer).

Parameters:
OPEN_CYC, 50_000_000, cycles the unlock relay stays energised after a correct attempt (1 s at 50 MHz)
ERR_CYC, 25_000_000, cycles the error indication lasts after a wrong attempt
LOCK_CYC, 250_000_000, cycles of lockout after MAX_FAIL consecutive failures
BLINK_HALF, 6_250_000, half-period in cycles of the led_err / buzzer blink
MAX_FAIL, 3, consecutive wrong attempts that trigger lockout (range 1..3)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
okay_key  in  1  confirm-key pulse; the same single-cycle pulse that drives the checker's confirm input
result  in  2  checker result code; valid on the cycle after okay_key is high
unlock  out  1  relay drive, high during OPEN
led_ok  out  1  green LED, high during OPEN
led_err  out  1  red LED, blinks during ERR, solid during LOCKOUT
buzzer  out  1  buzzer drive, equal to led_err during ERR, low otherwise
lockout  out  1  high during LOCKOUT
fail_cnt  out  2  current consecutive-failure count

Behaviour:
- Reset: one clock, synchronous, active-low. Reset is applied when rst_n is low at a clk rising edge. All outputs go to 0, state goes to IDLE, and the timer and fail_cnt clear. A reset mid-window aborts it immediately.
- key_d is a 1-cycle registered copy of okay_key. An attempt is evaluated on the edge where key_d = 1, sampling result on that edge.
- All outputs are registered. They change at the 2nd rising edge after the edge that samples okay_key high.
- States: IDLE, OPEN, ERR, LOCKOUT.
- IDLE with evaluation, result == 1: go to OPEN, clear fail_cnt.
- IDLE with evaluation, result == 2 or 3: fail_cnt + 1.
  - If the new count == MAX_FAIL: go to LOCKOUT and clear fail_cnt.
  - Otherwise: go to ERR.
- IDLE with evaluation, result == 0: no action.
- OPEN, ERR and LOCKOUT ignore evaluations. The attempt is dropped and fail_cnt is unchanged.
- Timer: cleared on state entry and increments each cycle. The state exits to IDLE on the edge where timer == DUR-1, where DUR = OPEN_CYC, ERR_CYC or LOCK_CYC. Each state therefore lasts exactly DUR cycles.
- Timer width: $clog2 of the largest DUR. No wrap occurs inside any state.
- Blink: a blink phase bit is set to 1 on ERR entry and toggles every BLINK_HALF cycles.
  - led_err = buzzer = phase during ERR.
  - In LOCKOUT: led_err = 1, buzzer = 0.
- Back-to-back: an evaluation landing on the same edge as a state exit to IDLE is ignored. IDLE acts on evaluations from the following cycle onward.
- okay_key held high for several cycles: each cycle with key_d = 1 while in IDLE counts as one evaluation. Debouncing and pulse-shaping happen upstream.
- fail_cnt persists across ERR windows. It is cleared only by a correct attempt, by lockout entry, or by reset.

Decomposition:
- Shared package elec_lock_pkg holds:
  - result codes RES_NONE = 2'd0, RES_OK = 2'd1, RES_ERR = 2'd2
  - state encoding ST_IDLE / ST_OPEN / ST_ERR / ST_LOCKOUT (2-bit)
- One sub-module, elec_lock_timer: a cycle counter with clear and a done flag (timer == DUR-1). It is instantiated once, and the parent muxes DUR by state.
- The blink phase logic stays in the parent.

Test Plan (overrides OPEN_CYC = 8, ERR_CYC = 6, LOCK_CYC = 20, BLINK_HALF = 2, MAX_FAIL = 3):
1. Reset then correct attempt: okay_key pulse at cycle 10 with result = 1 at cycle 11 -> unlock and led_ok high on cycles 12..19, low at 20; fail_cnt = 0.
2. Single wrong attempt: result = 2 -> fail_cnt = 1; led_err and buzzer show the pattern 1,1,0,0,1,1 over 6 cycles, then IDLE.
3. Three wrong attempts, each after the ERR window ends -> 3rd attempt enters LOCKOUT with lockout = led_err = 1 for 20 cycles, buzzer = 0, fail_cnt = 0.
4. Attempts during windows ignored: okay_key with result = 1 issued during ERR and during LOCKOUT -> no state change, unlock stays 0, fail_cnt unchanged.
5. Two failures then success -> fail_cnt goes 1, 2, 0; a following failure gives fail_cnt = 1 and ERR, not LOCKOUT.
6. Reset mid-OPEN (rst_n low for 1 cycle at OPEN cycle 3) -> unlock = 0 at the next edge, state IDLE; a subsequent correct attempt yields the full 8-cycle window.

Source files
------------

// File: rtl/elec_lock_actuator_pkg.sv
// Shared result codes, state encoding and indicator bundle for the lock actuator.
package elec_lock_pkg;

    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_OK   = 2'd1;
    localparam logic [1:0] RES_ERR  = 2'd2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_OPEN    = 2'd1;
    localparam logic [1:0] ST_ERR     = 2'd2;
    localparam logic [1:0] ST_LOCKOUT = 2'd3;

    typedef struct packed {
        logic unlock;
        logic led_ok;
        logic led_err;
        logic buzzer;
        logic lockout;
    } ind_t;

    // Codes 2 and 3 both count as a wrong attempt.
    function automatic logic is_fail(input logic [1:0] res);
        return res[1];
    endfunction

endpackage

// File: rtl/elec_lock_actuator_if.sv
// Checker-side inputs and board-side drive outputs of the lock actuator.
interface elec_lock_if;
    logic       okay_key;
    logic [1:0] result;
    logic       unlock;
    logic       led_ok;
    logic       led_err;
    logic       buzzer;
    logic       lockout;
    logic [1:0] fail_cnt;

    modport master (
        output okay_key, result,
        input  unlock, led_ok, led_err, buzzer, lockout, fail_cnt
    );

    modport slave (
        input  okay_key, result,
        output unlock, led_ok, led_err, buzzer, lockout, fail_cnt
    );
endinterface

// File: rtl/elec_lock_actuator_timer.sv
// Window cycle counter: held at zero while cleared, flags the last cycle of a window.
module elec_lock_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic [W-1:0] i_last,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) r_cnt <= '0;
        else                 r_cnt <= r_cnt + W'(1);
    end

    assign o_done = (r_cnt == i_last);

endmodule

// File: rtl/elec_lock_actuator.sv
// Turns checker verdicts into timed relay / LED / buzzer windows with failure lockout.
module elec_lock_actuator
    import elec_lock_pkg::*;
#(
    parameter int OPEN_CYC   = 50_000_000,
    parameter int ERR_CYC    = 25_000_000,
    parameter int LOCK_CYC   = 250_000_000,
    parameter int BLINK_HALF = 6_250_000,
    parameter int MAX_FAIL   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    elec_lock_if.slave  bus
);

    localparam int MAX_OE  = (OPEN_CYC > ERR_CYC) ? OPEN_CYC : ERR_CYC;
    localparam int MAX_DUR = (MAX_OE > LOCK_CYC) ? MAX_OE : LOCK_CYC;
    localparam int TW      = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;
    localparam int BW      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic          r_key_d;
    logic [1:0]    r_state;
    logic [1:0]    r_fail;
    logic          r_phase;
    logic [BW-1:0] r_bcnt;
    ind_t          r_ind;
    logic [1:0]    r_fail_out;

    logic [TW-1:0] w_last;
    logic          w_done;
    logic          w_clr;
    logic [1:0]    w_fail_nx;

    always_comb begin
        w_last = TW'(LOCK_CYC - 1);
        case (r_state)
            ST_OPEN: w_last = TW'(OPEN_CYC - 1);
            ST_ERR:  w_last = TW'(ERR_CYC - 1);
            default: w_last = TW'(LOCK_CYC - 1);
        endcase
    end

    // Held clear in IDLE so every window starts counting from zero.
    assign w_clr     = (r_state == ST_IDLE);
    assign w_fail_nx = r_fail + 2'd1;

    elec_lock_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .i_last (w_last),
        .o_done (w_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key_d <= 1'b0;
            r_state <= ST_IDLE;
            r_fail  <= 2'd0;
            r_phase <= 1'b0;
            r_bcnt  <= '0;
        end else begin
            r_key_d <= bus.okay_key;
            case (r_state)
                ST_IDLE: begin
                    if (r_key_d) begin
                        if (bus.result == RES_OK) begin
                            r_state <= ST_OPEN;
                            r_fail  <= 2'd0;
                        end else if (is_fail(bus.result)) begin
                            if (w_fail_nx == 2'(MAX_FAIL)) begin
                                r_state <= ST_LOCKOUT;
                                r_fail  <= 2'd0;
                            end else begin
                                r_state <= ST_ERR;
                                r_fail  <= w_fail_nx;
                                r_phase <= 1'b1;
                                r_bcnt  <= '0;
                            end
                        end
                    end
                end
                ST_ERR: begin
                    if (w_done) begin
                        r_state <= ST_IDLE;
                    end else if (r_bcnt == BW'(BLINK_HALF - 1)) begin
                        r_bcnt  <= '0;
                        r_phase <= ~r_phase;
                    end else begin
                        r_bcnt  <= r_bcnt + BW'(1);
                    end
                end
                default: begin
                    if (w_done) r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Indicators follow the registered state one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ind      <= '0;
            r_fail_out <= 2'd0;
        end else begin
            r_ind.unlock  <= (r_state == ST_OPEN);
            r_ind.led_ok  <= (r_state == ST_OPEN);
            r_ind.led_err <= (r_state == ST_LOCKOUT) || ((r_state == ST_ERR) && r_phase);
            r_ind.buzzer  <= (r_state == ST_ERR) && r_phase;
            r_ind.lockout <= (r_state == ST_LOCKOUT);
            r_fail_out    <= r_fail;
        end
    end

    assign bus.unlock   = r_ind.unlock;
    assign bus.led_ok   = r_ind.led_ok;
    assign bus.led_err  = r_ind.led_err;
    assign bus.buzzer   = r_ind.buzzer;
    assign bus.lockout  = r_ind.lockout;
    assign bus.fail_cnt = r_fail_out;

endmodule
